// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised synchronous FIFO with simultaneous read/write and status flags
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 1,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err,
    output logic [ADDR_WIDTH:0]   data_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

    typedef enum logic [2:0] {
        NO_OP        = 3'd0,
        WRITE        = 3'd1,
        READ         = 3'd2,
        WRITE_READ   = 3'd3,
        WR_ERR       = 3'd4,
        RD_ERR       = 3'd5,
        WR_ERR_RD    = 3'd6,
        WRITE_RD_ERR = 3'd7
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   head;
    logic [ADDR_WIDTH-1:0]   tail;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    wr_rej;
    logic                    rd_rej;

    assign full         = (data_count == DEPTH_C);
    assign empty        = (data_count == '0);
    assign almost_full  = (data_count >= AF_C);
    assign almost_empty = (data_count <= AE_C);

    // A write while full still goes through when paired with a read: it lands in the slot being freed.
    assign wr_acc = wr_en & (~full | rd_en);
    assign rd_acc = rd_en & ~empty;
    assign wr_rej = wr_en & ~wr_acc;
    assign rd_rej = rd_en & ~rd_acc;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[tail] <= d_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            data_count <= '0;
            d_out      <= '0;
            state      <= NO_OP;
        end else begin
            // Arithmetic updates keep X on the request inputs visible in the pointers and count.
            head       <= head + {{(ADDR_WIDTH-1){1'b0}}, rd_acc};
            tail       <= tail + {{(ADDR_WIDTH-1){1'b0}}, wr_acc};
            data_count <= data_count + {{ADDR_WIDTH{1'b0}}, wr_acc}
                                     - {{ADDR_WIDTH{1'b0}}, rd_acc};
            d_out      <= rd_acc ? mem[head] : '0;
            case ({wr_acc, wr_rej, rd_acc, rd_rej})
                4'b0000: state <= NO_OP;
                4'b1000: state <= WRITE;
                4'b0010: state <= READ;
                4'b1010: state <= WRITE_READ;
                4'b0100: state <= WR_ERR;
                4'b0001: state <= RD_ERR;
                4'b0110: state <= WR_ERR_RD;
                4'b1001: state <= WRITE_RD_ERR;
                default: state <= state_t'(3'bxxx);
            endcase
        end
    end

    assign wr_ack = (state == WRITE) || (state == WRITE_READ) || (state == WRITE_RD_ERR);
    assign wr_err = (state == WR_ERR) || (state == WR_ERR_RD);
    assign rd_ack = (state == READ) || (state == WRITE_READ) || (state == WR_ERR_RD);
    assign rd_err = (state == RD_ERR) || (state == WRITE_RD_ERR);

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - self-checking bench for sync_fifo_param (default and 16x16 configurations)
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        a_wr, a_rd;
    logic [31:0] a_din, a_dout;
    logic        a_full, a_empty, a_af, a_ae, a_wack, a_werr, a_rack, a_rerr;
    logic [3:0]  a_cnt;

    logic        b_wr, b_rd;
    logic [15:0] b_din, b_dout;
    logic        b_full, b_empty, b_af, b_ae, b_wack, b_werr, b_rack, b_rerr;
    logic [4:0]  b_cnt;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mq_a[$];
    logic [31:0] sb_a[$];
    logic [15:0] mq_b[$];
    logic [15:0] sb_b[$];
    bit          e_wack, e_werr, e_rack, e_rerr;

    always #5 clk = ~clk;

    sync_fifo_param dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(a_wr), .rd_en(a_rd), .d_in(a_din),
        .d_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .wr_ack(a_wack), .wr_err(a_werr), .rd_ack(a_rack),
        .rd_err(a_rerr), .data_count(a_cnt)
    );

    sync_fifo_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .AF_LEVEL(12), .AE_LEVEL(3)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(b_wr), .rd_en(b_rd), .d_in(b_din),
        .d_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .wr_ack(b_wack), .wr_err(b_werr), .rd_ack(b_rack),
        .rd_err(b_rerr), .data_count(b_cnt)
    );

    task automatic drive_a(input bit wr, input bit rd, input logic [31:0] din);
        bit wacc, racc;
        a_wr = wr; a_rd = rd; a_din = din;
        wacc = wr && (mq_a.size() < 8 || rd);
        racc = rd && (mq_a.size() > 0);
        e_wack = wacc; e_werr = wr && !wacc; e_rack = racc; e_rerr = rd && !racc;
        if (racc) sb_a.push_back(mq_a.pop_front());
        if (wacc) mq_a.push_back(din);
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic drive_b(input bit wr, input bit rd, input logic [15:0] din);
        bit wacc, racc;
        b_wr = wr; b_rd = rd; b_din = din;
        wacc = wr && (mq_b.size() < 16 || rd);
        racc = rd && (mq_b.size() > 0);
        e_wack = wacc; e_werr = wr && !wacc; e_rack = racc; e_rerr = rd && !racc;
        if (racc) sb_b.push_back(mq_b.pop_front());
        if (wacc) mq_b.push_back(din);
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if ({a_cnt, a_empty, a_ae, a_full, a_af, a_wack, a_werr, a_rack, a_rerr} !== 12'b0000_1100_0000) begin
            nerr++;
            $display("FAIL reset_a_status: got cnt=%0d e=%b ae=%b f=%b af=%b ack/err=%b%b%b%b want cnt=0 e=1 ae=1 rest 0",
                     a_cnt, a_empty, a_ae, a_full, a_af, a_wack, a_werr, a_rack, a_rerr);
        end
        nvec++;
        if (a_dout !== 32'h0) begin
            nerr++; $display("FAIL reset_a_dout: got %h want 0", a_dout);
        end
        nvec++;
        if ({b_cnt, b_empty, b_ae, b_full, b_af, b_dout} !== {5'd0, 4'b1100, 16'h0}) begin
            nerr++; $display("FAIL reset_b_status: got cnt=%0d e=%b ae=%b f=%b af=%b dout=%h want 0/1/1/0/0/0",
                             b_cnt, b_empty, b_ae, b_full, b_af, b_dout);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive_a(1'b0, 1'b0, 32'h0);
        nvec++;
        if ({a_cnt, a_empty, a_wack, a_werr, a_rack, a_rerr, a_dout} !== {4'd0, 5'b10000, 32'h0}) begin
            nerr++; $display("FAIL idle_a: got cnt=%0d e=%b flags=%b%b%b%b dout=%h want cnt=0 e=1 flags=0000 dout=0",
                             a_cnt, a_empty, a_wack, a_werr, a_rack, a_rerr, a_dout);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 9; i++) begin
            drive_a(1'b1, 1'b0, 32'h11 * i);
            nvec++;
            if ({a_wack, a_werr, a_rack, a_rerr} !== {e_wack, e_werr, e_rack, e_rerr}) begin
                nerr++; $display("FAIL fill_flags[%0d]: got %b%b%b%b want %b%b%b%b", i,
                                 a_wack, a_werr, a_rack, a_rerr, e_wack, e_werr, e_rack, e_rerr);
            end
            nvec++;
            if ({a_cnt, a_af, a_full} !== {4'((i > 8) ? 8 : i), (i >= 7), (i >= 8)}) begin
                nerr++; $display("FAIL fill_level[%0d]: got cnt=%0d af=%b full=%b want cnt=%0d af=%b full=%b", i,
                                 a_cnt, a_af, a_full, (i > 8) ? 8 : i, (i >= 7), (i >= 8));
            end
        end
        nvec++;
        if (a_werr !== 1'b1) begin
            nerr++; $display("FAIL fill_overflow_err: got %b want 1", a_werr);
        end
    endtask

    task automatic test_drain;
        logic [31:0] exp_d;
        for (int i = 1; i <= 9; i++) begin
            drive_a(1'b0, 1'b1, 32'h0);
            exp_d = e_rack ? sb_a.pop_front() : 32'h0;
            nvec++;
            if ({a_wack, a_werr, a_rack, a_rerr} !== {e_wack, e_werr, e_rack, e_rerr}) begin
                nerr++; $display("FAIL drain_flags[%0d]: got %b%b%b%b want %b%b%b%b", i,
                                 a_wack, a_werr, a_rack, a_rerr, e_wack, e_werr, e_rack, e_rerr);
            end
            nvec++;
            if (a_dout !== exp_d || (i <= 8 && a_dout !== 32'h11 * i)) begin
                nerr++; $display("FAIL drain_data[%0d]: got %h want %h", i, a_dout, exp_d);
            end
        end
        nvec++;
        if ({a_rerr, a_empty, a_cnt} !== {2'b11, 4'd0}) begin
            nerr++; $display("FAIL drain_underflow: got rd_err=%b empty=%b cnt=%0d want 1 1 0", a_rerr, a_empty, a_cnt);
        end
    endtask

    task automatic test_full_rw;
        logic [31:0] exp_d;
        for (int i = 1; i <= 8; i++) drive_a(1'b1, 1'b0, 32'h11 * i);
        drive_a(1'b1, 1'b1, 32'h99);
        exp_d = sb_a.pop_front();
        nvec++;
        if ({a_wack, a_rack, a_werr, a_rerr, a_cnt, a_dout} !== {4'b1100, 4'd8, exp_d}) begin
            nerr++; $display("FAIL full_rw: got wack=%b rack=%b werr=%b rerr=%b cnt=%0d dout=%h want 1 1 0 0 8 %h",
                             a_wack, a_rack, a_werr, a_rerr, a_cnt, a_dout, exp_d);
        end
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b0, 1'b1, 32'h0);
            exp_d = e_rack ? sb_a.pop_front() : 32'h0;
            nvec++;
            if (a_dout !== exp_d || a_rack !== 1'b1) begin
                nerr++; $display("FAIL full_rw_read[%0d]: got %h rack=%b want %h rack=1", i, a_dout, a_rack, exp_d);
            end
        end
        nvec++;
        if (a_dout !== 32'h99 || a_empty !== 1'b1) begin
            nerr++; $display("FAIL full_rw_last: got %h empty=%b want 99 empty=1", a_dout, a_empty);
        end
    endtask

    task automatic test_empty_rw;
        drive_a(1'b1, 1'b1, 32'hAB);
        nvec++;
        if ({a_wack, a_werr, a_rack, a_rerr, a_cnt, a_dout} !== {4'b1001, 4'd1, 32'h0}) begin
            nerr++; $display("FAIL empty_rw: got flags=%b%b%b%b cnt=%0d dout=%h want 1001 1 0",
                             a_wack, a_werr, a_rack, a_rerr, a_cnt, a_dout);
        end
        drive_a(1'b0, 1'b1, 32'h0);
        nvec++;
        if (a_dout !== sb_a.pop_front() || a_rack !== 1'b1) begin
            nerr++; $display("FAIL empty_rw_read: got %h rack=%b want ab rack=1", a_dout, a_rack);
        end
    endtask

    task automatic test_wide;
        logic [15:0] exp_d;
        int sz;
        int nwr = 0;
        for (int i = 0; i < 120; i++) begin
            bit wr, rd;
            wr = ($urandom_range(0, 99) < 60);
            rd = ($urandom_range(0, 99) < ((i % 40) < 20 ? 30 : 70));
            drive_b(wr, rd, 16'($urandom));
            if (e_wack) nwr++;
            sz = mq_b.size();
            exp_d = e_rack ? sb_b.pop_front() : 16'h0;
            nvec++;
            if ({b_wack, b_werr, b_rack, b_rerr} !== {e_wack, e_werr, e_rack, e_rerr} || b_dout !== exp_d) begin
                nerr++; $display("FAIL wide_op[%0d]: got flags=%b%b%b%b dout=%h want %b%b%b%b %h", i,
                                 b_wack, b_werr, b_rack, b_rerr, b_dout, e_wack, e_werr, e_rack, e_rerr, exp_d);
            end
            nvec++;
            if ({b_cnt, b_full, b_empty, b_af, b_ae} !== {5'(sz), sz == 16, sz == 0, sz >= 12, sz <= 3}) begin
                nerr++; $display("FAIL wide_level[%0d]: got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d f=%b e=%b af=%b ae=%b",
                                 i, b_cnt, b_full, b_empty, b_af, b_ae, sz, sz == 16, sz == 0, sz >= 12, sz <= 3);
            end
        end
        nvec++;
        if (nwr < 20) begin
            nerr++; $display("FAIL wide_wrap_coverage: got %0d accepted writes want >= 20", nwr);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 6; i++) drive_b(1'b1, 1'b0, 16'h5000 + 16'(i));
        drive_b(1'b0, 1'b1, 16'h0);
        b_wr = 1'b1; b_din = 16'hDEAD;
        #3;
        reset_n = 1'b0;
        #1;
        nvec++;
        if ({b_cnt, b_empty, b_ae, b_full, b_af, b_wack, b_werr, b_rack, b_rerr, b_dout} !==
            {5'd0, 8'b1100_0000, 16'h0}) begin
            nerr++; $display("FAIL reset_mid: got cnt=%0d e=%b ae=%b f=%b af=%b flags=%b%b%b%b dout=%h want 0 1 1 0 0 0000 0",
                             b_cnt, b_empty, b_ae, b_full, b_af, b_wack, b_werr, b_rack, b_rerr, b_dout);
        end
        mq_a.delete(); sb_a.delete(); mq_b.delete(); sb_b.delete();
        b_wr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        drive_b(1'b1, 1'b0, 16'h1234);
        drive_b(1'b0, 1'b1, 16'h0);
        nvec++;
        if (b_dout !== sb_b.pop_front() || b_cnt !== 5'd0) begin
            nerr++; $display("FAIL after_reset_rw: got dout=%h cnt=%0d want 1234 0", b_dout, b_cnt);
        end
    endtask

    initial begin
        a_wr = 0; a_rd = 0; a_din = '0;
        b_wr = 0; b_rd = 0; b_din = '0;
        test_reset;
        test_fill;
        test_drain;
        test_full_rw;
        test_empty_rw;
        test_wide;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the next generation of the team's fixed 32x8 FIFO. Data width and depth are set by parameters. Adds simultaneous read+write in one cycle, programmable almost_full/almost_empty thresholds, and a combined operation status. Sits between producer/consumer blocks in the same clock domain. Storage is an internal register array with one write port and one read port.

Parameters:
DATA_WIDTH, 32, width of d_in/d_out
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries
AF_LEVEL, DEPTH-1, almost_full asserted when data_count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserted when data_count <= AE_LEVEL

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  write request
rd_en  in  1  read request
d_in  in  DATA_WIDTH  write data
d_out  out  DATA_WIDTH  read data, registered
full  out  1  data_count == DEPTH
empty  out  1  data_count == 0
almost_full  out  1  data_count >= AF_LEVEL
almost_empty  out  1  data_count <= AE_LEVEL
wr_ack  out  1  previous cycle's write was accepted
wr_err  out  1  previous cycle's write was rejected (full)
rd_ack  out  1  previous cycle's read was accepted
rd_err  out  1  previous cycle's read was rejected (empty)
data_count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. Reset clears head, tail, data_count, d_out, and all ack/err flags to 0. Afterwards empty=1, almost_empty=1, full=0, almost_full=0. Array contents are not cleared. Reset mid-operation discards all stored data immediately.
- Accept rules, evaluated from the registered data_count at the rising edge:
  - wr_acc = wr_en & (~full | rd_en)
  - rd_acc = rd_en & ~empty
- Simultaneous request when full: both are accepted; the oldest entry is read and the new entry is written into the freed slot.
- Simultaneous request when empty: the write is accepted and the read is rejected (rd_err). There is no fall-through path.
- Operation state register, updated every edge: NO_OP, WRITE, READ, WRITE_READ, WR_ERR, RD_ERR, WR_ERR_RD, WRITE_RD_ERR. The error combinations cover a rejected request paired with an accepted one.
- Flags decode from the state register:
  - wr_ack = 1 in WRITE, WRITE_READ, WRITE_RD_ERR
  - wr_err = 1 in WR_ERR, WR_ERR_RD
  - rd_ack = 1 in READ, WRITE_READ, WR_ERR_RD
  - rd_err = 1 in RD_ERR, WRITE_RD_ERR
- Flag latency is 1 cycle after the requesting edge.
- Write: mem[tail] <= d_in, tail <= tail+1. The pointer wraps modulo DEPTH naturally at width ADDR_WIDTH.
- Read: d_out <= mem[head], head <= head+1 with the same wrap. d_out is valid one cycle after the accepting edge, aligned with rd_ack.
- On an edge with no accepted read, d_out <= 0.
- data_count update:
  - +1 on write-only accept
  - -1 on read-only accept
  - unchanged on both or neither
- data_count never exceeds DEPTH and never underflows.
- full, empty, almost_full and almost_empty are combinational from data_count (same cycle as the count). AF_LEVEL/AE_LEVEL equal to 0 or DEPTH are legal.
- A rejected request changes no pointer, count or memory word.
- X on wr_en/rd_en drives state, pointers and flags to X (simulation visibility only).

Test Plan:
- Reset then idle -> data_count=0, empty=1, almost_empty=1, d_out=0, all ack/err=0.
- Write 8 words 0x11..0x88 back-to-back (defaults) -> wr_ack high each following cycle, almost_full at count 7, full at 8; 9th write -> wr_err=1, count stays 8, memory unchanged.
- Read 8 words from full -> d_out=0x11..0x88 in order, rd_ack aligned; 9th read -> rd_err=1, d_out=0, empty=1.
- Full FIFO, wr_en=rd_en=1 with d_in=0x99 -> d_out=0x11, wr_ack=rd_ack=1, count stays 8, next 8 reads return 0x22..0x88 then 0x99.
- Empty FIFO, wr_en=rd_en=1 with d_in=0xAB -> wr_ack=1, rd_err=1, count=1; next read returns 0xAB.
- DATA_WIDTH=16, ADDR_WIDTH=4, AF_LEVEL=12, AE_LEVEL=3: write 20 times with interleaved reads past a pointer wrap -> data order preserved, almost flags toggle at 12/3, reset asserted mid-burst -> immediate count=0, flags at reset values.
